// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// The fetch unit drives the request through the master modport; the memory drives the response through the slave modport.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns fetch_pc, keeps one request outstanding and holds one instruction for decode.
// Optional macro IFETCH_MISALIGN_CHECK_EN turns misaligned redirects into a flagged NOP instead of fetching.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  ifetch_unit_if.master      imem,
  output logic [31:0]        instr,
  output logic [31:0]        pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic               instr_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        kill;
  logic        req_q;
  logic [31:0] redirect_tgt;

  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc;

`ifndef IFETCH_MISALIGN_CHECK_EN
  // Low target bits are dropped silently in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // NOTE: every register here is updated with non-blocking assignments so that all
  // decisions in one cycle see the state from the previous edge, never a half-updated one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      kill        <= 1'b0;
      req_q       <= 1'b0;
      instr       <= NOP_INSTR;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      instr_misalign <= 1'b0;
`endif
    end else begin
`ifdef IFETCH_MISALIGN_CHECK_EN
      // A misaligned target never reaches memory; decode sees a flagged NOP at that PC.
      if (state != IDLE && redirect_valid && redirect_pc[1:0] != 2'b00) begin
        state          <= HOLD;
        req_q          <= 1'b0;
        kill           <= 1'b0;
        fetch_pc       <= redirect_tgt + 32'd4;
        instr          <= NOP_INSTR;
        pc             <= redirect_pc;
        instr_valid    <= 1'b1;
        instr_misalign <= 1'b1;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            state <= REQ;
            req_q <= 1'b1;
          end

          REQ: begin
            if (redirect_valid) fetch_pc <= redirect_tgt;
            if (imem.imem_gnt) begin
              state <= WAIT;
              req_q <= 1'b0;
              // The granted address is now stale if a redirect arrived with the grant.
              kill  <= redirect_valid;
            end
          end

          WAIT: begin
            if (imem.imem_rvalid) begin
              if (redirect_valid) begin
                fetch_pc <= redirect_tgt;
                kill     <= 1'b0;
                state    <= REQ;
                req_q    <= 1'b1;
              end else if (kill) begin
                kill  <= 1'b0;
                state <= REQ;
                req_q <= 1'b1;
              end else begin
                instr       <= imem.imem_rdata;
                pc          <= fetch_pc;
                instr_valid <= 1'b1;
                fetch_pc    <= fetch_pc + 32'd4;
                state       <= HOLD;
              end
            end else if (redirect_valid) begin
              kill     <= 1'b1;
              fetch_pc <= redirect_tgt;
            end
          end

          HOLD: begin
            if (redirect_valid || instr_ready) begin
              if (redirect_valid) fetch_pc <= redirect_tgt;
              instr_valid <= 1'b0;
              instr       <= NOP_INSTR;
              state       <= REQ;
              req_q       <= 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
              instr_misalign <= 1'b0;
`endif
            end
          end

          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
